// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and helpers for the CNN pooling stage: stage
//               state encoding, default element width, signed max and ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int CNN_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_CLEAR = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } pool_state_t;

  // Helpers work on sign-extended 32-bit values so any element width < 32 fits.
  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [31:0] relu(input logic signed [31:0] a);
    return (a < 0) ? 32'sd0 : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_counter
// Description : Steps the top-left corner of the 2x2 pooling window across
//               the map in row-major order and tracks the output index.
//               An odd trailing row/column is never visited.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_counter #(
  parameter int MAP_W = 6,
  parameter int MAP_H = 6,
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [IDX_W-1:0] out_idx,
  output logic             last
);

  localparam int LAST_ROW = 2 * (MAP_H / 2 - 1);
  localparam int LAST_COL = 2 * (MAP_W / 2 - 1);

  assign last = (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

  // Window position: clear to origin, advance by 2 columns, wrap to next row pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row     <= '0;
      col     <= '0;
      out_idx <= '0;
    end else if (clear) begin
      row     <= '0;
      col     <= '0;
      out_idx <= '0;
    end else if (step) begin
      out_idx <= out_idx + IDX_W'(1);
      if (col == COL_W'(LAST_COL)) begin
        col <= '0;
        row <= row + ROW_W'(2);
      end else begin
        col <= col + COL_W'(2);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_maxpool_relu_stage.sv
`default_nettype none
// ============================================================================
// Module      : cnn_maxpool_relu_stage
// Description : Reads the layer-2 feature map from shared memory, applies
//               2x2 stride-2 max-pooling and ReLU, writes the pooled map back.
//               Six cycles per window: 4 reads, 1 drain, 1 write.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_maxpool_relu_stage
  import cnn_pkg::*;
#(
  parameter int DATA_W   = CNN_DATA_W,
  parameter int MAP_W    = 6,
  parameter int MAP_H    = 6,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(MAP_H) + 1;
  localparam int COL_W = $clog2(MAP_W) + 1;

  pool_state_t              state;
  logic [1:0]               k;
  logic                     last_win;
  logic                     rd_valid;
  logic signed [DATA_W-1:0] acc;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col;
  logic [ADDR_W-1:0]        out_idx;
  logic                     win_last;
  logic                     cnt_clear;
  logic                     cnt_step;
  logic                     first_elem;
  logic signed [31:0]       acc_ext;
  logic signed [31:0]       rd_ext;
  logic signed [31:0]       max_ext;

  // Source address of window element kk (bit 1 = row offset, bit 0 = column offset).
  function automatic logic [ADDR_W-1:0] src_addr(input int r, input int c, input int kk);
    return ADDR_W'(SRC_BASE + (r + kk / 2) * MAP_W + c + kk % 2);
  endfunction

  // Counter is zeroed on entry to Clear and advanced as the window drains,
  // so the next window's first address is ready when Write hands back to Read.
  assign cnt_clear  = (state == ST_START) && !start;
  assign cnt_step   = (state == ST_DRAIN);
  // Data for element 0 returns in the Read cycle with k==1.
  assign first_elem = (state == ST_READ) && (k == 2'd1);
  assign acc_ext    = {{(32-DATA_W){acc[DATA_W-1]}}, acc};
  assign rd_ext     = {{(32-DATA_W){rd_data[DATA_W-1]}}, rd_data};
  assign max_ext    = smax(acc_ext, rd_ext);

  pool_window_counter #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .IDX_W (ADDR_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .step    (cnt_step),
    .row     (row),
    .col     (col),
    .out_idx (out_idx),
    .last    (win_last)
  );

  // Running signed maximum of the returning window elements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      acc      <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_valid) begin
        acc <= first_elem ? rd_data : DATA_W'(max_ext);
      end
    end
  end

  // Sequencer with registered memory strobes and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      last_win <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_START;
        end
        ST_START: begin
          if (!start) begin
            state <= ST_CLEAR;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state   <= ST_READ;
          rd_en   <= 1'b1;
          rd_addr <= src_addr(int'(row), int'(col), 0);
        end
        ST_READ: begin
          if (k == 2'd3) begin
            state <= ST_DRAIN;
            k     <= '0;
            rd_en <= 1'b0;
          end else begin
            k       <= k + 2'd1;
            rd_addr <= src_addr(int'(row), int'(col), int'(k) + 1);
          end
        end
        ST_DRAIN: begin
          // Element 3 is on rd_data now; fold it in directly for the write data.
          state    <= ST_WRITE;
          wr_en    <= 1'b1;
          wr_addr  <= ADDR_W'(DST_BASE + int'(out_idx));
          wr_data  <= DATA_W'(relu(max_ext));
          last_win <= win_last;
        end
        ST_WRITE: begin
          wr_en <= 1'b0;
          if (last_win) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= ST_READ;
            rd_en   <= 1'b1;
            rd_addr <= src_addr(int'(row), int'(col), 0);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_maxpool_relu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_maxpool_relu_stage
// Description : Directed bench for the pooling stage: a 4x4 instance and an
//               odd 5x5 instance, each with its own synchronous-read memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_maxpool_relu_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       load_a = 1'b0, load_b = 1'b0;

  logic       rd_en_a, wr_en_a, busy_a, done_a;
  logic [7:0] rd_addr_a, wr_addr_a, wr_data_a, rdq_a;
  logic       rd_en_b, wr_en_b, busy_b, done_b;
  logic [7:0] rd_addr_b, wr_addr_b, wr_data_b, rdq_b;

  logic [7:0] mem_a [256];
  logic [7:0] img_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] img_b [256];

  int checks = 0, failures = 0;
  int wr_cnt_a = 0, done_cnt_a = 0, wr_cnt_b = 0, done_cnt_b = 0;
  int overlap = 0, bad_b = 0;
  int early_rd, busy_gap, rd_at1, rd_at2, addr_at2;

  always #5 clk = ~clk;

  cnn_maxpool_relu_stage #(.DATA_W(8), .MAP_W(4), .MAP_H(4), .ADDR_W(8),
                           .SRC_BASE(0), .DST_BASE(64)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rdq_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a));

  cnn_maxpool_relu_stage #(.DATA_W(8), .MAP_W(5), .MAP_H(5), .ADDR_W(8),
                           .SRC_BASE(0), .DST_BASE(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rdq_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b));

  // Synchronous-read memories with bulk preload from the image arrays.
  always @(posedge clk) begin
    if (rd_en_a) rdq_a <= mem_a[rd_addr_a];
    if (load_a) mem_a <= img_a;
    else if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
    if (rd_en_b) rdq_b <= mem_b[rd_addr_b];
    if (load_b) mem_b <= img_b;
    else if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
  end

  // Activity monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en_a) wr_cnt_a <= wr_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (wr_en_b) wr_cnt_b <= wr_cnt_b + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if ((rd_en_a && wr_en_a) || (rd_en_b && wr_en_b)) overlap <= overlap + 1;
    if (rd_en_b && (rd_addr_b >= 8'd20 || (rd_addr_b % 5) == 4)) bad_b <= bad_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_load_a();
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
  endtask

  // One run of instance A; optional abort by reset and optional extra start pulse.
  task automatic run_a(input int hold, input int abort_at, input int repulse_at, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    early_rd = 0;
    busy_gap = 0;
    rd_at1 = -1;
    rd_at2 = -1;
    addr_at2 = -1;
    start_a = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rd_en_a) early_rd++;
    end
    start_a = 1'b0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) rd_at1 = int'(rd_en_a);
      if (n == 2) begin
        rd_at2 = int'(rd_en_a);
        addr_at2 = int'(rd_addr_a);
      end
      if (n == repulse_at) start_a = 1'b1;
      if (n == repulse_at + 1) start_a = 1'b0;
      if (n == abort_at) begin
        check("abort_in_read", {31'd0, rd_en_a}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_outs_zero", {28'd0, rd_en_a, wr_en_a, busy_a, done_a}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      if (done_a) begin
        cyc = n;
        check("busy_low_in_done", {31'd0, busy_a}, 32'd0);
        break;
      end
      if (!busy_a) busy_gap++;
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc, w0, d0;
    for (int i = 0; i < 256; i++) begin
      img_a[i] = 8'h00;
      img_b[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_a", {3'd0, rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a}, 32'd0);
    check("reset_b", {3'd0, rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4x4 ramp, start held for 5 cycles
    for (int i = 0; i < 16; i++) img_a[i] = 8'(i);
    for (int i = 64; i < 68; i++) img_a[i] = 8'h55;
    do_load_a();
    w0 = wr_cnt_a;
    d0 = done_cnt_a;
    run_a(5, -1, -1, cyc);
    check("no_rd_while_start", early_rd, 0);
    check("no_rd_in_clear", rd_at1, 0);
    check("rd_after_clear", rd_at2, 1);
    check("first_rd_addr", addr_at2, 0);
    check("latency_4x4", cyc, 26);
    check("busy_throughout", busy_gap, 0);
    check("ramp_w0", mem_a[64], 8'd5);
    check("ramp_w1", mem_a[65], 8'd7);
    check("ramp_w2", mem_a[66], 8'd13);
    check("ramp_w3", mem_a[67], 8'd15);
    check("ramp_writes", wr_cnt_a - w0, 4);
    check("ramp_done_pulses", done_cnt_a - d0, 1);

    // Signed windows: all-negative, extremes, mid-window max, last-element max
    img_a[0] = 8'hFD;  img_a[1] = 8'hFF;  img_a[4] = 8'hF8;  img_a[5] = 8'h80;
    img_a[2] = 8'h80;  img_a[3] = 8'h7F;  img_a[6] = 8'h00;  img_a[7] = 8'hFF;
    img_a[8] = 8'h9C;  img_a[9] = 8'd20;  img_a[12] = 8'd90; img_a[13] = 8'hFF;
    img_a[10] = 8'd1;  img_a[11] = 8'd2;  img_a[14] = 8'd3;  img_a[15] = 8'd100;
    do_load_a();
    run_a(1, -1, -1, cyc);
    check("relu_all_neg", mem_a[64], 8'd0);
    check("max_extremes", mem_a[65], 8'd127);
    check("max_elem2", mem_a[66], 8'd90);
    check("max_elem3", mem_a[67], 8'd100);

    // Reset during the second window's reads, then a clean restart
    for (int i = 0; i < 16; i++) img_a[i] = 8'(i);
    do_load_a();
    run_a(1, 9, -1, cyc);
    check("abort_partial_w0", mem_a[64], 8'd5);
    check("abort_untouched_w1", mem_a[65], 8'h55);
    w0 = wr_cnt_a;
    repeat (4) @(negedge clk);
    check("abort_quiet", wr_cnt_a - w0, 0);
    run_a(1, -1, -1, cyc);
    check("restart_latency", cyc, 26);
    check("restart_w1", mem_a[65], 8'd7);
    check("restart_w3", mem_a[67], 8'd15);

    // Start pulsed again mid-run is ignored
    w0 = wr_cnt_a;
    d0 = done_cnt_a;
    run_a(1, -1, 10, cyc);
    repeat (10) @(negedge clk);
    check("repulse_latency", cyc, 26);
    check("repulse_writes", wr_cnt_a - w0, 4);
    check("repulse_done_pulses", done_cnt_a - d0, 1);

    // Odd 5x5 map on instance B
    for (int i = 0; i < 25; i++) img_b[i] = 8'(i);
    for (int i = 64; i < 68; i++) img_b[i] = 8'h55;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    w0 = wr_cnt_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done_b) begin
        cyc = n;
        break;
      end
    end
    @(negedge clk);
    check("latency_5x5", cyc, 26);
    check("odd_w0", mem_b[64], 8'd6);
    check("odd_w1", mem_b[65], 8'd8);
    check("odd_w2", mem_b[66], 8'd16);
    check("odd_w3", mem_b[67], 8'd18);
    check("odd_writes", wr_cnt_b - w0, 4);
    check("odd_no_edge_reads", bad_b, 0);
    check("rd_wr_exclusive", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
